// File: rtl/data_memory.sv
// Byte-addressable data memory and load/store unit for the single-cycle RV32I core.
// Combinational loads, synchronous byte-lane stores, sticky fault capture and a store counter.
module data_memory #(
  parameter int DEPTH_WORDS = 1024,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [2:0]       funct3,
  output logic [31:0]      rdata,
  output logic             misaligned,
  output logic             fault,
  output logic [31:0]      fault_addr,
  output logic [CNT_W-1:0] store_count
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] BYTE_CAP = 33'(DEPTH_WORDS) << 2;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] widx;
  logic [1:0]    lane;
  logic          access;
  logic          f3_ok;
  logic          in_range;
  logic          mis_raw;
  logic          legal;
  logic          store_ok;
  logic [31:0]   word;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [3:0]    be;
  logic [31:0]   wlanes;

  assign widx   = addr[AW+1:2];
  assign lane   = addr[1:0];
  assign access = mem_read | mem_write;

  // Unsigned loads are not valid store encodings, so a store with funct3[2] set is illegal.
  always_comb begin
    f3_ok    = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    in_range = {1'b0, addr} < BYTE_CAP;
    mis_raw  = (((funct3 == 3'b001) || (funct3 == 3'b101)) && addr[0]) ||
               ((funct3 == 3'b010) && (lane != 2'b00));
    legal    = f3_ok && in_range && !mis_raw && !(mem_write && funct3[2]);
    store_ok = mem_write && legal;
  end

  assign misaligned = access && mis_raw;

  always_comb begin
    word   = mem[widx];
    byte_v = 8'h00;
    case (lane)
      2'd0: byte_v = word[7:0];
      2'd1: byte_v = word[15:8];
      2'd2: byte_v = word[23:16];
      2'd3: byte_v = word[31:24];
      default: byte_v = 8'h00;
    endcase
    half_v = addr[1] ? word[31:16] : word[15:0];
    rdata  = 32'h0;
    if (mem_read && legal) begin
      case (funct3)
        3'b000:  rdata = {{24{byte_v[7]}}, byte_v};
        3'b100:  rdata = {24'h0, byte_v};
        3'b001:  rdata = {{16{half_v[15]}}, half_v};
        3'b101:  rdata = {16'h0, half_v};
        3'b010:  rdata = word;
        default: rdata = 32'h0;
      endcase
    end
  end

  // Store data is replicated across lanes; the byte enables pick which lanes land.
  always_comb begin
    be     = 4'b0000;
    wlanes = wdata;
    case (funct3)
      3'b000: begin
        be     = 4'b0001 << lane;
        wlanes = {4{wdata[7:0]}};
      end
      3'b001: begin
        be     = addr[1] ? 4'b1100 : 4'b0011;
        wlanes = {2{wdata[15:0]}};
      end
      3'b010: begin
        be     = 4'b1111;
        wlanes = wdata;
      end
      default: begin
        be     = 4'b0000;
        wlanes = wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && store_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault       <= 1'b0;
      fault_addr  <= 32'h0;
      store_count <= '0;
    end else begin
      if (access && !legal) begin
        fault <= 1'b1;
        if (!fault) fault_addr <= addr;
      end
      if (store_ok) store_count <= store_count + CNT_W'(1);
    end
  end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Byte-addressable data memory and load/store unit for the single-cycle RV32I core.
- Takes the ALU-computed address and rs2 store data.
- Produces the load result that feeds the 32-bit writeback 2:1 mux (ALU result vs memory data, selected by MemtoReg).
- Handles RV32I byte/half/word sizing, sign/zero extension, misalignment/range checking, a sticky fault register and a store counter.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words. Byte capacity is DEPTH_WORDS*4; must be a power of two.
- CNT_W, 16: width of the store counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- addr  input  32  byte address from the ALU
- wdata  input  32  store data (rs2). Low byte/half is used for SB/SH.
- mem_read  input  1  load enable
- mem_write  input  1  store enable
- funct3  input  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU
- rdata  output  32  load result to the writeback mux (combinational)
- misaligned  output  1  combinational: current access is misaligned
- fault  output  1  sticky registered error flag
- fault_addr  output  32  address of the first faulting access
- store_count  output  CNT_W  number of committed stores

Behaviour:
- Word index is addr[log2(DEPTH_WORDS)+1:2]. Byte lane is addr[1:0].
- An access is legal when all of the following hold:
  - funct3 is in {000, 001, 010, 100, 101}
  - addr < DEPTH_WORDS*4
  - it is not misaligned.
- misaligned is 1 when (mem_read | mem_write) and either:
  - half access (001/101) with addr[0] = 1, or
  - word access (010) with addr[1:0] != 0.
  - Otherwise misaligned = 0.
- Read path: combinational, zero latency, as required by the single-cycle datapath.
  - rdata = 0 when mem_read = 0 or the access is illegal.
  - LB: sign-extend the selected byte lane. LBU: zero-extend it.
  - LH: sign-extend the half at lane addr[1]. LHU: zero-extend it.
  - LW: full word.
- Write path: synchronous on the rising edge of clk.
  - A store commits only when mem_write = 1, the access is legal, and rst = 0.
  - SB writes one byte lane, SH writes two lanes, SW writes four. Unselected lanes are unchanged.
  - funct3 100/101 with mem_write = 1 is illegal: no write.
- Read-during-write, same word: rdata shows the pre-edge contents. New data is visible combinationally after the edge.
- mem_read and mem_write both high:
  - Store commits normally.
  - rdata reflects pre-edge contents.
  - Counts as one access for fault purposes.
- Fault:
  - On the rising edge, if (mem_read | mem_write) and the access is illegal, fault is set to 1.
  - fault_addr captures addr, but only if fault was 0 before that edge. The first fault wins; later faults do not overwrite it.
  - fault clears only on rst.
- store_count:
  - Increments by 1 on each committed store.
  - Wraps from 2^CNT_W-1 to 0.
  - Faulting stores are not counted.
- Reset:
  - rst asserted asynchronously forces fault = 0, fault_addr = 0, store_count = 0 immediately.
  - Memory array contents are not reset.
  - Stores are suppressed while rst = 1, including a store coincident with the rst edge.
- Memory contents after power-up are undefined. Benches must write before reading.

Test Plan:
- Word round-trip: SW addr 0x10, wdata 0xDEADBEEF; then LW 0x10 -> rdata 0xDEADBEEF, store_count 1, fault 0.
- Byte/half extension: memory[0x20] = 0x80FF7F01; then:
  - LB 0x23 -> 0xFFFFFF80
  - LBU 0x23 -> 0x00000080
  - LH 0x22 -> 0xFFFF80FF
  - LHU 0x20 -> 0x00007F01
  - SB 0x21 with wdata 0xAA, then LW 0x20 -> 0x80FFAA01
- Misalignment:
  - SW 0x12 -> misaligned 1, no write (LW 0x10 unchanged), fault 1, fault_addr 0x12, store_count unchanged.
  - A subsequent LH 0x15 keeps fault_addr 0x12.
- Out of range: LW 0x1000 with DEPTH_WORDS = 1024 -> rdata 0, misaligned 0, fault 1, fault_addr 0x1000.
- Reset mid-operation: assert rst between edges while store_count = 3 and fault = 1 -> all three registered outputs 0 before the next edge. A SW held during rst does not write; the previously stored data is still readable after release.
- Counter wrap: with CNT_W = 4, perform 16 legal stores -> store_count returns to 0. Same-word read-during-write returns old data before the edge and new data after it.
